// File: rtl/irq_button_conditioner_pkg.sv
// Shared definitions for the IRQ button conditioner and the control unit:
// debounce state encodings, IRQ polarity and a reset-level helper.
package irq_button_conditioner_pkg;

    typedef enum logic [1:0] {
        S_REL   = 2'd0,
        S_PWAIT = 2'd1,
        S_PRS   = 2'd2,
        S_RWAIT = 2'd3
    } deb_state_e;

    // Level driven on irq_req while a request is pending.
    localparam logic IRQ_ASSERT = 1'b1;

    // Pin level seen when the button is released.
    function automatic logic idle_level(input int active_low);
        return (active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/irq_button_conditioner_if.sv
// Button/IRQ bundle between the pin side, the conditioner and control.
// master drives the pin and the acknowledge, slave is the conditioner.
interface irq_button_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             btn_in;
    logic             irq_ack;
    logic             irq_req;
    logic             btn_level;
    logic             overrun;
    logic [CNT_W-1:0] irq_count;

    modport master (
        output btn_in,
        output irq_ack,
        input  irq_req,
        input  btn_level,
        input  overrun,
        input  irq_count
    );

    modport slave (
        input  btn_in,
        input  irq_ack,
        output irq_req,
        output btn_level,
        output overrun,
        output irq_count
    );
endinterface

// File: rtl/irq_button_conditioner_sync_chain.sv
// Multi-flop synchroniser for asynchronous single-bit inputs.
// Reset loads every stage with INIT so no spurious edge follows reset.
module sync_chain #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic CLK,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the chain.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{INIT}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/irq_button_conditioner.sv
// Synchronise, debounce and latch the external IRQ button for control.
// Build option: define IRQ_STATS_EN to build the accepted-press counter.
module irq_button_conditioner
    import irq_button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 20,
    parameter int ACTIVE_LOW  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                      CLK,
    input  logic                      rst,
    irq_button_conditioner_if.slave   bus
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYCLES - 1);
    localparam logic IDLE = idle_level(ACTIVE_LOW);

    deb_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          req_q, req_d;
    logic          ovr_q, ovr_d;
    logic          sync_s;
    logic          p;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (IDLE)
    ) u_sync (
        .CLK (CLK),
        .rst (rst),
        .d_i (bus.btn_in),
        .q_o (sync_s)
    );

    // Polarity-corrected level: 1 means pressed.
    assign p = (ACTIVE_LOW != 0) ? ~sync_s : sync_s;

    // Debounce state, wait counter and registered press pulse.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= S_REL;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Next state: a level change must hold for DEB_CYCLES waits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            S_REL: begin
                if (p) begin
                    state_d = S_PWAIT;
                    cnt_d   = '0;
                end
            end
            S_PWAIT: begin
                if (!p) begin
                    state_d = S_REL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PRS;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRS: begin
                if (!p) begin
                    state_d = S_RWAIT;
                    cnt_d   = '0;
                end
            end
            S_RWAIT: begin
                if (p) begin
                    state_d = S_PRS;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_REL;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending request and sticky overrun flag.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            req_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            req_q <= req_d;
            ovr_q <= ovr_d;
        end
    end

    // A press wins over a same-cycle ack; a press on a held request overruns.
    always_comb begin
        req_d = req_q;
        ovr_d = ovr_q;
        if (press_q) begin
            req_d = 1'b1;
            if (req_q && !bus.irq_ack) begin
                ovr_d = 1'b1;
            end
        end else if (bus.irq_ack && req_q) begin
            req_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

`ifdef IRQ_STATS_EN
    logic [CNT_W-1:0] stat_q;

    // Count accepted presses, wrapping at the counter width.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else if (press_q) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign bus.irq_count = stat_q;
`else
    assign bus.irq_count = '0;
`endif

    assign bus.irq_req   = req_q ? IRQ_ASSERT : ~IRQ_ASSERT;
    assign bus.btn_level = (state_q == S_PRS) || (state_q == S_RWAIT);
    assign bus.overrun   = ovr_q;

endmodule
